// File: rtl/instr_encoder_pkg.sv
// Shared types and constants for the RV32I instruction encoder / program loader.
// Range constants are consumed only when INSTR_ENCODER_RANGE_CHECK_EN is defined.
package instr_encoder_pkg;

    localparam int unsigned INSTR_W = 32;
    localparam int unsigned REG_W   = 5;
    localparam int unsigned F3_W    = 3;
    localparam int unsigned F7_W    = 7;
    localparam int unsigned OPC_W   = 7;
    localparam int unsigned TYPE_W  = 3;

    localparam logic [OPC_W-1:0] OPC_R      = 7'b0110011;
    localparam logic [OPC_W-1:0] OPC_I      = 7'b0010011;
    localparam logic [OPC_W-1:0] OPC_LOAD   = 7'b0000011;
    localparam logic [OPC_W-1:0] OPC_STORE  = 7'b0100011;
    localparam logic [OPC_W-1:0] OPC_BRANCH = 7'b1100011;
    localparam logic [OPC_W-1:0] OPC_JAL    = 7'b1101111;
    localparam logic [OPC_W-1:0] OPC_JALR   = 7'b1100111;

    typedef enum logic [TYPE_W-1:0] {
        IT_R       = 3'd0,
        IT_I       = 3'd1,
        IT_LOAD    = 3'd2,
        IT_STORE   = 3'd3,
        IT_BRANCH  = 3'd4,
        IT_JAL     = 3'd5,
        IT_JALR    = 3'd6,
        IT_ILLEGAL = 3'd7
    } instr_type_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ENC   = 2'd1,
        ST_WRITE = 2'd2
    } state_e;

    // Legal signed immediate ranges per format
    localparam int IMM12_MIN = -2048;
    localparam int IMM12_MAX = 2047;
    localparam int SHAMT_MIN = 0;
    localparam int SHAMT_MAX = 31;
    localparam int IMM_B_MIN = -4096;
    localparam int IMM_B_MAX = 4094;
    localparam int IMM_J_MIN = -1048576;
    localparam int IMM_J_MAX = 1048574;

    typedef struct packed {
        instr_type_e         itype;
        logic [REG_W-1:0]    rd;
        logic [REG_W-1:0]    rs1;
        logic [REG_W-1:0]    rs2;
        logic [F3_W-1:0]     funct3;
        logic [F7_W-1:0]     funct7;
        logic [INSTR_W-1:0]  imm;
    } cmd_t;

    // I-type funct3 values that carry a shift amount instead of imm[11:0]
    function automatic logic is_shift_f3(input logic [F3_W-1:0] f3);
        return (f3 == 3'b001) || (f3 == 3'b101);
    endfunction

endpackage

// File: rtl/instr_pack.sv
// Combinational RV32I packer: command fields -> 32-bit instruction word plus reject flag.
// INSTR_ENCODER_RANGE_CHECK_EN adds immediate range/alignment rejection.
module instr_pack
    import instr_encoder_pkg::*;
(
    input  cmd_t               cmd,
    output logic [INSTR_W-1:0] word_c,
    output logic               err_c
);

    logic [INSTR_W-1:0] imm;
    logic               shift_op;
    logic               type_err;
    logic               range_err;
    logic               unused_imm_hi;

    assign imm           = cmd.imm;
    assign shift_op      = is_shift_f3(cmd.funct3);
    assign unused_imm_hi = ^imm[31:21];

    // Standard RV32I field placement per format
    always_comb begin
        word_c   = '0;
        type_err = 1'b0;
        unique case (cmd.itype)
            IT_R:      word_c = {cmd.funct7, cmd.rs2, cmd.rs1, cmd.funct3, cmd.rd, OPC_R};
            IT_I: begin
                if (shift_op) begin
                    word_c = {cmd.funct7, imm[4:0], cmd.rs1, cmd.funct3, cmd.rd, OPC_I};
                end else begin
                    word_c = {imm[11:0], cmd.rs1, cmd.funct3, cmd.rd, OPC_I};
                end
            end
            IT_LOAD:   word_c = {imm[11:0], cmd.rs1, cmd.funct3, cmd.rd, OPC_LOAD};
            IT_STORE:  word_c = {imm[11:5], cmd.rs2, cmd.rs1, cmd.funct3, imm[4:0], OPC_STORE};
            IT_BRANCH: word_c = {imm[12], imm[10:5], cmd.rs2, cmd.rs1, cmd.funct3,
                                 imm[4:1], imm[11], OPC_BRANCH};
            IT_JAL:    word_c = {imm[20], imm[10:1], imm[11], imm[19:12], cmd.rd, OPC_JAL};
            IT_JALR:   word_c = {imm[11:0], cmd.rs1, 3'b000, cmd.rd, OPC_JALR};
            default:   type_err = 1'b1;
        endcase
    end

`ifdef INSTR_ENCODER_RANGE_CHECK_EN
    logic signed [INSTR_W-1:0] simm;
    assign simm = $signed(imm);

    // Reject immediates that would not survive truncation into their field
    always_comb begin
        range_err = 1'b0;
        unique case (cmd.itype)
            IT_I: begin
                if (shift_op) begin
                    range_err = (simm < SHAMT_MIN) || (simm > SHAMT_MAX);
                end else begin
                    range_err = (simm < IMM12_MIN) || (simm > IMM12_MAX);
                end
            end
            IT_LOAD, IT_STORE, IT_JALR:
                range_err = (simm < IMM12_MIN) || (simm > IMM12_MAX);
            IT_BRANCH:
                range_err = (simm < IMM_B_MIN) || (simm > IMM_B_MAX) || imm[0];
            IT_JAL:
                range_err = (simm < IMM_J_MIN) || (simm > IMM_J_MAX) || imm[0];
            default:
                range_err = 1'b0;
        endcase
    end
`else
    assign range_err = 1'b0;
`endif

    assign err_c = type_err | range_err;

endmodule

// File: rtl/instr_encoder.sv
// RV32I instruction encoder / program loader: accepts commands, packs them, writes to imem.
// Optional INSTR_ENCODER_RANGE_CHECK_EN enables immediate range errors in instr_pack.
module instr_encoder
    import instr_encoder_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  load_addr,
    input  logic [ADDR_WIDTH-1:0] start_addr,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [TYPE_W-1:0]     in_type,
    input  logic [REG_W-1:0]      in_rd,
    input  logic [REG_W-1:0]      in_rs1,
    input  logic [REG_W-1:0]      in_rs2,
    input  logic [F3_W-1:0]       in_funct3,
    input  logic [F7_W-1:0]       in_funct7,
    input  logic [INSTR_W-1:0]    in_imm,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [INSTR_W-1:0]    mem_wdata,
    input  logic                  mem_ready,
    output logic                  err,
    output logic                  full,
    output logic [ADDR_WIDTH-1:0] wr_ptr
);

    state_e                state;
    state_e                state_d;
    cmd_t                  cmd_q;
    cmd_t                  cmd_d;
    cmd_t                  in_cmd;
    cmd_t                  pack_cmd;
    logic [INSTR_W-1:0]    pack_word;
    logic                  pack_err;
    logic                  err_d;
    logic                  mem_we_d;
    logic                  full_d;
    logic [ADDR_WIDTH-1:0] mem_addr_d;
    logic [ADDR_WIDTH-1:0] wr_ptr_d;
    logic [INSTR_W-1:0]    mem_wdata_d;

    assign in_cmd.itype  = instr_type_e'(in_type);
    assign in_cmd.rd     = in_rd;
    assign in_cmd.rs1    = in_rs1;
    assign in_cmd.rs2    = in_rs2;
    assign in_cmd.funct3 = in_funct3;
    assign in_cmd.funct7 = in_funct7;
    assign in_cmd.imm    = in_imm;

    // In IDLE the packer sees the live command so err can be registered at acceptance
    assign pack_cmd = (state == ST_IDLE) ? in_cmd : cmd_q;

    instr_pack u_pack (
        .cmd    (pack_cmd),
        .word_c (pack_word),
        .err_c  (pack_err)
    );

    assign in_ready = (state == ST_IDLE) && !full && !load_addr;

    always_comb begin
        state_d     = state;
        cmd_d       = cmd_q;
        err_d       = 1'b0;
        mem_we_d    = mem_we;
        mem_addr_d  = mem_addr;
        mem_wdata_d = mem_wdata;
        full_d      = full;
        wr_ptr_d    = wr_ptr;
        unique case (state)
            ST_IDLE: begin
                if (load_addr) begin
                    wr_ptr_d = start_addr;
                    full_d   = 1'b0;
                end else if (in_valid && !full) begin
                    cmd_d   = in_cmd;
                    err_d   = pack_err;
                    state_d = ST_ENC;
                end
            end
            ST_ENC: begin
                if (err) begin
                    state_d = ST_IDLE;
                end else begin
                    mem_wdata_d = pack_word;
                    mem_addr_d  = wr_ptr;
                    mem_we_d    = 1'b1;
                    state_d     = ST_WRITE;
                end
            end
            ST_WRITE: begin
                // Pointer saturates at the top address instead of wrapping
                if (mem_ready) begin
                    mem_we_d = 1'b0;
                    state_d  = ST_IDLE;
                    if (&wr_ptr) begin
                        full_d = 1'b1;
                    end else begin
                        wr_ptr_d = wr_ptr + ADDR_WIDTH'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= ST_IDLE;
            cmd_q     <= cmd_t'('0);
            err       <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            full      <= 1'b0;
            wr_ptr    <= '0;
        end else begin
            state     <= state_d;
            cmd_q     <= cmd_d;
            err       <= err_d;
            mem_we    <= mem_we_d;
            mem_addr  <= mem_addr_d;
            mem_wdata <= mem_wdata_d;
            full      <= full_d;
            wr_ptr    <= wr_ptr_d;
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench for instr_encoder: random commands vs. an arithmetic RV32I encoding model.
module tb_instr_encoder;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        load_addr = 1'b0;
    logic [7:0]  start_addr = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  in_type = '0;
    logic [4:0]  in_rd = '0;
    logic [4:0]  in_rs1 = '0;
    logic [4:0]  in_rs2 = '0;
    logic [2:0]  in_funct3 = '0;
    logic [6:0]  in_funct7 = '0;
    logic [31:0] in_imm = '0;
    logic        mem_we;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ready = 1'b0;
    logic        err;
    logic        full;
    logic [7:0]  wr_ptr;

    instr_encoder #(.ADDR_WIDTH(8)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .load_addr  (load_addr),
        .start_addr (start_addr),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_type    (in_type),
        .in_rd      (in_rd),
        .in_rs1     (in_rs1),
        .in_rs2     (in_rs2),
        .in_funct3  (in_funct3),
        .in_funct7  (in_funct7),
        .in_imm     (in_imm),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_ready  (mem_ready),
        .err        (err),
        .full       (full),
        .wr_ptr     (wr_ptr)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit          is_err;
        logic [7:0]  addr;
        logic [31:0] word;
        int          acc;
    } exp_t;

    exp_t        sb[$];
    int          tests = 0;
    int          fails = 0;
    logic [7:0]  mptr = '0;
    bit          mfull = 1'b0;
    int          rmode = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Encoding computed from the format rules with shifts and masks
    function automatic void ref_encode(input logic [2:0] t, input logic [4:0] rd,
                                       input logic [4:0] rs1, input logic [4:0] rs2,
                                       input logic [2:0] fn3, input logic [6:0] fn7,
                                       input logic [31:0] imm,
                                       output logic [31:0] w, output bit e);
        logic [31:0] f7, f3, r_d, r1, r2, im;
        int          si;
        f7 = 32'(fn7); f3 = 32'(fn3); r_d = 32'(rd); r1 = 32'(rs1); r2 = 32'(rs2);
        im = imm; si = int'(imm);
        w = '0; e = 1'b0;
        case (t)
            3'd0: w = (f7 << 25) | (r2 << 20) | (r1 << 15) | (f3 << 12) | (r_d << 7) | 32'h33;
            3'd1: begin
                if (fn3 == 3'd1 || fn3 == 3'd5)
                    w = (f7 << 25) | ((im & 32'h1F) << 20) | (r1 << 15) | (f3 << 12) | (r_d << 7) | 32'h13;
                else
                    w = ((im & 32'hFFF) << 20) | (r1 << 15) | (f3 << 12) | (r_d << 7) | 32'h13;
            end
            3'd2: w = ((im & 32'hFFF) << 20) | (r1 << 15) | (f3 << 12) | (r_d << 7) | 32'h03;
            3'd3: w = (((im >> 5) & 32'h7F) << 25) | (r2 << 20) | (r1 << 15) | (f3 << 12)
                      | ((im & 32'h1F) << 7) | 32'h23;
            3'd4: w = (((im >> 12) & 32'h1) << 31) | (((im >> 5) & 32'h3F) << 25) | (r2 << 20)
                      | (r1 << 15) | (f3 << 12) | (((im >> 1) & 32'hF) << 8)
                      | (((im >> 11) & 32'h1) << 7) | 32'h63;
            3'd5: w = (((im >> 20) & 32'h1) << 31) | (((im >> 1) & 32'h3FF) << 21)
                      | (((im >> 11) & 32'h1) << 20) | (((im >> 12) & 32'hFF) << 12)
                      | (r_d << 7) | 32'h6F;
            3'd6: w = ((im & 32'hFFF) << 20) | (r1 << 15) | (r_d << 7) | 32'h67;
            default: e = 1'b1;
        endcase
`ifdef INSTR_ENCODER_RANGE_CHECK_EN
        case (t)
            3'd1: begin
                if (fn3 == 3'd1 || fn3 == 3'd5) e = (si < 0) || (si > 31);
                else                            e = (si < -2048) || (si > 2047);
            end
            3'd2, 3'd3, 3'd6: e = (si < -2048) || (si > 2047);
            3'd4: e = (si < -4096) || (si > 4094) || (si % 2 != 0);
            3'd5: e = (si < -1048576) || (si > 1048574) || (si % 2 != 0);
            default: ;
        endcase
`else
        if (si == 0) e = e;
`endif
    endfunction

    task automatic issue(input logic [2:0] t, input logic [4:0] rd, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                         input logic [31:0] imm, input bit use_force, input logic [31:0] force_word);
        exp_t        e;
        logic [31:0] w;
        bit          er;
        int          k;
        ref_encode(t, rd, rs1, rs2, f3, f7, imm, w, er);
        if (use_force) w = force_word;
        @(posedge clk); #1;
        in_type = t; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
        in_funct3 = f3; in_funct7 = f7; in_imm = imm; in_valid = 1'b1;
        k = 0;
        @(negedge clk);
        while (!in_ready && k < 100) begin
            @(negedge clk);
            k++;
        end
        if (!in_ready) begin
            tests++; fails++;
            $display("FAIL accept_timeout: in_ready=0 after %0d cycles, expected 1", k);
        end else begin
            e.is_err = er; e.addr = mptr; e.word = w; e.acc = cyc;
            sb.push_back(e);
            if (!er) begin
                if (mptr == 8'hFF) mfull = 1'b1;
                else mptr = mptr + 8'd1;
            end
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int k = 0;
        while (sb.size() != 0 && k < 300) begin
            @(negedge clk);
            k++;
        end
        if (sb.size() != 0) begin
            tests++; fails++;
            $display("FAIL drain_timeout: %0d responses pending, expected 0", sb.size());
            sb.delete();
        end
        @(negedge clk);
    endtask

    // mem_ready driver: 0 always ready, 1 random, 2 stalled
    initial begin : ready_drv
        forever begin
            @(posedge clk); #1;
            case (rmode)
                0:       mem_ready = 1'b1;
                1:       mem_ready = 1'($urandom_range(0, 1));
                default: mem_ready = 1'b0;
            endcase
        end
    end

    // Monitor: pops the scoreboard whenever the DUT reports err or a write
    initial begin : monitor
        exp_t e;
        bit   head_seen;
        head_seen = 1'b0;
        forever begin
            @(negedge clk);
            if (!rstn) begin
                head_seen = 1'b0;
            end else if (err) begin
                if (sb.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL unexpected_err: err=1 with no pending command, expected err=0");
                end else begin
                    e = sb.pop_front();
                    chk("err_raised", 32'(err), 32'(e.is_err));
                    chk("err_latency", 32'(cyc), 32'(e.acc + 1));
                    head_seen = 1'b0;
                end
            end else if (mem_we) begin
                if (sb.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL unexpected_write: mem_we=1 addr=0x%02h with no pending command", mem_addr);
                end else begin
                    e = sb[0];
                    chk("mem_we_legal", 32'(mem_we), 32'(!e.is_err));
                    if (!head_seen) chk("we_latency", 32'(cyc), 32'(e.acc + 2));
                    chk("mem_addr", 32'(mem_addr), 32'(e.addr));
                    chk("mem_wdata", mem_wdata, e.word);
                    chk("in_ready_busy", 32'(in_ready), 32'(0));
                    head_seen = 1'b1;
                    if (mem_ready || e.is_err) begin
                        void'(sb.pop_front());
                        head_seen = 1'b0;
                    end
                end
            end else if (sb.size() != 0) begin
                e = sb[0];
                if ((e.is_err && cyc > e.acc + 1) || (!e.is_err && !head_seen && cyc > e.acc + 2)) begin
                    tests++; fails++;
                    $display("FAIL missing_output: no %s by cycle %0d, expected at %0d",
                             e.is_err ? "err" : "write", cyc, e.is_err ? e.acc + 1 : e.acc + 2);
                    void'(sb.pop_front());
                    head_seen = 1'b0;
                end
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        logic [2:0]  t;
        logic [31:0] imm;
        int          x;

        repeat (2) @(posedge clk);
        #2 rstn = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'(1));
        chk("rst_mem_we", 32'(mem_we), 32'(0));
        chk("rst_mem_addr", 32'(mem_addr), 32'(0));
        chk("rst_mem_wdata", mem_wdata, 32'h0);
        chk("rst_err", 32'(err), 32'(0));
        chk("rst_full", 32'(full), 32'(0));
        chk("rst_wr_ptr", 32'(wr_ptr), 32'(0));

        // Reference vectors with literal expected words
        rmode = 0;
        issue(3'd0, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0, 1'b1, 32'h002081B3);
        wait_idle();
        chk("wr_ptr_after_first", 32'(wr_ptr), 32'(1));
        issue(3'd1, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFF, 1'b1, 32'hFFF00093);
        issue(3'd3, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd8, 1'b1, 32'h0020A423);
        issue(3'd4, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFC, 1'b1, 32'hFE000EE3);
        wait_idle();
        chk("wr_ptr_after_vectors", 32'(wr_ptr), 32'(mptr));

        // Illegal type: err pulse, no write, pointer unchanged
        issue(3'd7, 5'd5, 5'd6, 5'd7, 3'd1, 7'd3, 32'd12, 1'b0, 32'h0);
        wait_idle();
        chk("wr_ptr_after_err", 32'(wr_ptr), 32'(mptr));
`ifdef INSTR_ENCODER_RANGE_CHECK_EN
        issue(3'd5, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3, 1'b0, 32'h0);
        wait_idle();
        chk("wr_ptr_after_jal_odd", 32'(wr_ptr), 32'(mptr));
`endif

        // Backpressure: write held while mem_ready is low
        rmode = 2;
        issue(3'd6, 5'd9, 5'd4, 5'd0, 3'd5, 7'd0, 32'd100, 1'b0, 32'h0);
        repeat (5) @(negedge clk);
        chk("bp_mem_we_held", 32'(mem_we), 32'(1));
        chk("bp_in_ready", 32'(in_ready), 32'(0));
        rmode = 0;
        wait_idle();
        chk("bp_wr_ptr", 32'(wr_ptr), 32'(mptr));

        // Top-of-memory saturation and reload
        @(posedge clk); #1;
        load_addr = 1'b1; start_addr = 8'd254;
        @(negedge clk);
        chk("load_in_ready", 32'(in_ready), 32'(0));
        @(posedge clk); #1;
        load_addr = 1'b0; mptr = 8'd254; mfull = 1'b0;
        @(negedge clk);
        chk("load_wr_ptr", 32'(wr_ptr), 32'(254));
        issue(3'd0, 5'd1, 5'd2, 5'd3, 3'd7, 7'd32, 32'd0, 1'b0, 32'h0);
        issue(3'd2, 5'd4, 5'd5, 5'd0, 3'd2, 7'd0, 32'd16, 1'b0, 32'h0);
        wait_idle();
        chk("full_set", 32'(full), 32'(mfull));
        chk("full_wr_ptr", 32'(wr_ptr), 32'(255));
        chk("full_in_ready", 32'(in_ready), 32'(0));
        @(posedge clk); #1 in_valid = 1'b1;
        repeat (4) @(negedge clk);
        chk("full_no_write", 32'(mem_we), 32'(0));
        @(posedge clk); #1;
        in_valid = 1'b0; load_addr = 1'b1; start_addr = 8'd0;
        @(posedge clk); #1 load_addr = 1'b0;
        mptr = 8'd0; mfull = 1'b0;
        @(negedge clk);
        chk("reload_full", 32'(full), 32'(0));
        chk("reload_wr_ptr", 32'(wr_ptr), 32'(0));

        // Randomised traffic with random memory backpressure
        rmode = 1;
        for (int n = 0; n < 150; n++) begin
            t = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 2))
                0:       imm = $urandom;
                1: begin x = int'($urandom_range(0, 8191)) - 4096; imm = x; end
                default: begin x = int'($urandom_range(0, 40)) - 4; imm = x; end
            endcase
            if (!mfull)
                issue(t, 5'($urandom), 5'($urandom), 5'($urandom), 3'($urandom),
                      7'($urandom), imm, 1'b0, 32'h0);
        end
        rmode = 0;
        wait_idle();
        chk("rand_wr_ptr", 32'(wr_ptr), 32'(mptr));

        // Asynchronous reset in the middle of a stalled write
        rmode = 2;
        issue(3'd0, 5'd7, 5'd8, 5'd9, 3'd4, 7'd0, 32'd0, 1'b0, 32'h0);
        for (int k = 0; k < 10 && !mem_we; k++) @(negedge clk);
        chk("pre_reset_we", 32'(mem_we), 32'(1));
        @(posedge clk); #3 rstn = 1'b0;
        #1 chk("reset_async_we", 32'(mem_we), 32'(0));
        sb.delete(); mptr = '0; mfull = 1'b0; rmode = 0;
        @(posedge clk); @(posedge clk); #2 rstn = 1'b1;
        @(negedge clk);
        chk("rst2_in_ready", 32'(in_ready), 32'(1));
        chk("rst2_mem_we", 32'(mem_we), 32'(0));
        chk("rst2_mem_addr", 32'(mem_addr), 32'(0));
        chk("rst2_mem_wdata", mem_wdata, 32'h0);
        chk("rst2_err", 32'(err), 32'(0));
        chk("rst2_full", 32'(full), 32'(0));
        chk("rst2_wr_ptr", 32'(wr_ptr), 32'(0));

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/instr_encoder.md
# instr_encoder

Sequential RV32I instruction encoder and program loader. It accepts instruction-class commands (type plus register, funct and immediate fields) over a valid/ready handshake and packs each into a 32-bit instruction word. It writes each word into instruction memory at an auto-incrementing word address. It is the encode-side counterpart of the opcode control decoder and is used to build test programs in the core's instruction memory.

## Interface
- ADDR_WIDTH, 8, instruction-memory word-address width
- clk  in  1  clock, rising edge
- rstn  in  1  asynchronous, active-low reset
- load_addr  in  1  load write pointer from start_addr (honoured only in IDLE)
- start_addr  in  ADDR_WIDTH  new write pointer value
- in_valid  in  1  command valid
- in_ready  out  1  command accepted when in_valid & in_ready
- in_type  in  3  0 R, 1 I, 2 LOAD, 3 STORE, 4 BRANCH, 5 JAL, 6 JALR, 7 illegal
- in_rd, in_rs1, in_rs2  in  5 each  register fields
- in_funct3  in  3  funct3 (forced 000 for JALR; unused for JAL)
- in_funct7  in  7  funct7 (R type, and I-type shifts)
- in_imm  in  32  signed immediate (byte offset for BRANCH/JAL)
- mem_we  out  1  write request, held until mem_ready
- mem_addr  out  ADDR_WIDTH  word address
- mem_wdata  out  32  encoded instruction
- mem_ready  in  1  memory accepts write this cycle
- err  out  1  one-cycle pulse: command rejected, nothing written
- full  out  1  last address written; no further commands accepted
- wr_ptr  out  ADDR_WIDTH  next write address

## Operation
- FSM states:
  - IDLE: in_ready = !full & !load_addr. Handshake latches all fields and moves to ENC. load_addr sets wr_ptr=start_addr and clears full.
  - ENC: registers the packed word and error flag. Error → err=1 for that cycle, return to IDLE, wr_ptr unchanged. No error → WRITE.
  - WRITE: mem_we=1; mem_addr=wr_ptr; mem_wdata=registered word. On mem_ready: wr_ptr increments and the FSM returns to IDLE. If wr_ptr was all-ones, full=1 and wr_ptr holds (no wrap).
- Packing, standard RV32I formats:
  - opcodes R 0110011, I 0010011, LOAD 0000011, STORE 0100011, BRANCH 1100011, JAL 1101111, JALR 1100111
  - I type with funct3 001/101: [31:25]=in_funct7, [24:20]=in_imm[4:0]
  - other I/LOAD/JALR: [31:20]=in_imm[11:0]
  - S: imm[11:5]→[31:25], imm[4:0]→[11:7]
  - B: imm[12|10:5]→[31:25], imm[4:1|11]→[11:7]
  - J: imm[20|10:1|11|19:12]→[31:12]
  - R ignores in_imm
- in_type 7 always raises err.
- load_addr outside IDLE is ignored. In IDLE, load_addr has priority over in_valid.

## Timing
- Reset values: state IDLE, in_ready=1, mem_we=0, mem_addr=0, mem_wdata=0, err=0, full=0, wr_ptr=0.
- Accept in cycle N → ENC in N+1 → mem_we high from N+2. Best case, one command per 3 cycles.
- While mem_we=1 and mem_ready=0: mem_addr and mem_wdata are stable, and in_ready=0.
- err fires in cycle N+1 relative to acceptance.
- Reset asserted mid-operation aborts immediately: mem_we drops asynchronously and the pending command is lost.

## Configuration
- INSTR_ENCODER_RANGE_CHECK_EN defined: additional err conditions, with no write.
  - I/LOAD/JALR/STORE imm outside [-2048, 2047].
  - Shift imm outside [0, 31].
  - BRANCH imm outside [-4096, 4094] or odd.
  - JAL imm outside [-1048576, 1048574] or odd.
- Undefined: immediates are truncated silently to the field bits; err only for in_type 7.

## Structure
- Package instr_encoder_pkg holds:
  - opcode localparams
  - the 3-bit instruction-type enum typedef
  - FSM state typedef
  - immediate range constants
- Sub-module instr_pack: purely combinational. Takes the latched fields and produces the 32-bit word plus err. The range checks live inside it under the macro.

## Test plan
- R type rd=3, rs1=1, rs2=2, funct3=0, funct7=0 after reset → mem_addr=0, mem_wdata=0x002081B3, wr_ptr=1.
- I type rd=1, rs1=0, funct3=0, imm=-1 → 0xFFF00093. STORE rs1=1, rs2=2, funct3=010, imm=8 → 0x0020A423.
- BRANCH rs1=rs2=0, funct3=0, imm=-4 → 0xFE000EE3. With the macro: JAL imm=3 → err pulse in cycle N+1, mem_we never asserted, wr_ptr unchanged.
- Backpressure: hold mem_ready=0 for 3 cycles during WRITE → mem_we, mem_addr and mem_wdata held constant, in_ready=0. mem_ready=1 → wr_ptr increments next edge.
- ADDR_WIDTH=2: four valid commands → addresses 0..3 written, full=1, in_ready=0, wr_ptr=3. load_addr with start_addr=0 → full=0, wr_ptr=0.
- Assert rstn low during WRITE → mem_we=0 immediately. After release, all outputs are at their reset values.
